// File: rtl/d8_pkg.sv
// Shared types, widths and opcode constants for the d8 ALU select and writeback stages.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package d8_pkg;

  localparam int DATA_W   = 8;
  localparam int REG_W    = 3;
  localparam int OP_W     = 8;
  localparam int NUM_REGS = 1 << REG_W;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [REG_W-1:0]  reg_idx_t;
  typedef logic [OP_W-1:0]   op_t;

  // ALU-class opcodes: only these update the condition flags at writeback.
  localparam op_t OP_ALU_01 = 8'h01;
  localparam op_t OP_ALU_02 = 8'h02;
  localparam op_t OP_ALU_03 = 8'h03;
  localparam op_t OP_ALU_04 = 8'h04;

  // One pending result as carried from the select stage to the register file.
  typedef struct packed {
    op_t      op;
    data_t    data;
    logic     carry;
    reg_idx_t dst;
  } wb_entry_t;

  function automatic logic is_alu_op(input op_t op);
    return (op == OP_ALU_01) || (op == OP_ALU_02) ||
           (op == OP_ALU_03) || (op == OP_ALU_04);
  endfunction

endpackage

// File: rtl/d8_alu_wb_if.sv
// Result handshake from the ALU output select stage into the writeback block.
// Latency: none (wiring only).
// Backpressure: valid/ready; a transfer happens on an edge where both are high.
interface d8_alu_wb_if;
  import d8_pkg::*;

  logic     in_valid;
  logic     in_ready;
  op_t      in_op;
  data_t    in_data;
  logic     in_carry;
  reg_idx_t in_dst;

  // Select stage drives the result, writeback block returns ready.
  modport master (
    output in_valid,
    output in_op,
    output in_data,
    output in_carry,
    output in_dst,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_op,
    input  in_data,
    input  in_carry,
    input  in_dst,
    output in_ready
  );

endinterface

// File: rtl/d8_wb_fifo.sv
// Pending-result buffer: circular FIFO of wb_entry_t with per-slot valid/dst visibility.
// Latency: an entry pushed on edge N is at the head from edge N onward (poppable at N+1).
// Backpressure: caller must not push when full nor pop when empty; occ exposes the count.
module d8_wb_fifo
  import d8_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  wb_entry_t             push_entry,
  input  logic                  pop,
  output wb_entry_t             head,
  output logic [CNT_W-1:0]      occ,
  output logic [DEPTH-1:0]      entry_vld,
  output reg_idx_t [DEPTH-1:0]  entry_dst
);

  localparam int PTR_W = $clog2(DEPTH);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [DEPTH-1:0] vld;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pointer, occupancy and slot-valid bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
      vld    <= '0;
    end else begin
      if (push) begin
        wr_ptr      <= ptr_inc(wr_ptr);
        vld[wr_ptr] <= 1'b1;
      end
      if (pop) begin
        rd_ptr      <= ptr_inc(rd_ptr);
        vld[rd_ptr] <= 1'b0;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Entry storage needs no reset: the valid bits gate every use of it.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  assign head      = mem[rd_ptr];
  assign entry_vld = vld;

  // Expose every slot's destination so the parent can run hazard compares.
  always_comb begin
    entry_dst = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_dst[i] = mem[i].dst;
    end
  end

endmodule

// File: rtl/d8_alu_wb.sv
// Writeback stage: buffers ALU results, commits head to the 8x8 register file and flags.
// Latency: push on edge N, earliest commit on edge N+1, wb_valid high the cycle after commit.
// Backpressure: in_ready low when the buffer holds DEPTH entries; wb_stall freezes commits.
module d8_alu_wb
  import d8_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  d8_alu_wb_if.slave     in_bus,
  input  logic           wb_stall,
  input  reg_idx_t       rf_raddr_a,
  output data_t          rf_rdata_a,
  input  reg_idx_t       rf_raddr_b,
  output data_t          rf_rdata_b,
  output logic           hazard_a,
  output logic           hazard_b,
  output logic           flag_z,
  output logic           flag_n,
  output logic           flag_c,
  output logic           wb_valid,
  output reg_idx_t       wb_addr,
  output logic           busy
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [CNT_W-1:0]     occ;
  logic                 ready;
  logic                 push;
  logic                 pop;
  wb_entry_t            push_entry;
  wb_entry_t            head;
  logic [DEPTH-1:0]     entry_vld;
  reg_idx_t [DEPTH-1:0] entry_dst;
  data_t                rf [NUM_REGS];

  // Ready comes from the registered count only, so it never depends on in_valid.
  assign ready           = (occ < CNT_W'(DEPTH));
  assign in_bus.in_ready = ready;
  assign push            = in_bus.in_valid & ready;
  assign busy            = (occ != '0);
  assign pop             = busy & ~wb_stall;

  // Pack the incoming result into a buffer entry.
  always_comb begin
    push_entry       = '0;
    push_entry.op    = in_bus.in_op;
    push_entry.data  = in_bus.in_data;
    push_entry.carry = in_bus.in_carry;
    push_entry.dst   = in_bus.in_dst;
  end

  d8_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .occ        (occ),
    .entry_vld  (entry_vld),
    .entry_dst  (entry_dst)
  );

  // Register file: head commits when not stalled; reset clears every register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        rf[i] <= '0;
      end
    end else if (pop) begin
      rf[head.dst] <= head.data;
    end
  end

  // Reads see committed state only; a same-edge commit shows up after the edge.
  assign rf_rdata_a = rf[rf_raddr_a];
  assign rf_rdata_b = rf[rf_raddr_b];

  // Flags follow only ALU-class commits and hold otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_c <= 1'b0;
    end else if (pop && is_alu_op(head.op)) begin
      flag_z <= (head.data == '0);
      flag_n <= head.data[DATA_W-1];
      flag_c <= head.carry;
    end
  end

  // One-cycle commit notification; the address holds between commits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_addr  <= '0;
    end else begin
      wb_valid <= pop;
      if (pop) begin
        wb_addr <= head.dst;
      end
    end
  end

  // Flag a read address that a still-buffered result is about to overwrite.
  always_comb begin
    hazard_a = 1'b0;
    hazard_b = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_vld[i] && (entry_dst[i] == rf_raddr_a)) hazard_a = 1'b1;
      if (entry_vld[i] && (entry_dst[i] == rf_raddr_b)) hazard_b = 1'b1;
    end
  end

endmodule

// File: doc/d8_alu_wb.md
D8_ALU_WB -- requirements
Module: d8_alu_wb

Interface
REQ-001 The block SHALL expose a parameter DEPTH, default 2, giving the number of pending-result buffer entries (legal range 2..4).
REQ-002 The block SHALL expose these ports, clock and reset first:
  clk          in   1  single clock; all state updates on rising edge
  rst_n        in   1  synchronous, active-low reset
  in_valid     in   1  result offered by the ALU output select stage
  in_ready     out  1  block can accept a result this cycle
  in_op        in   8  opcode accompanying the result
  in_data      in   8  selected result (ALU sum or pass-through operand)
  in_carry     in   1  ALU carry-out for in_op
  in_dst       in   3  destination register index
  wb_stall     in   1  writeback inhibited this cycle
  rf_raddr_a   in   3  read port A address
  rf_rdata_a   out  8  read port A data
  rf_raddr_b   in   3  read port B address
  rf_rdata_b   out  8  read port B data
  hazard_a     out  1  pending buffered write targets rf_raddr_a
  hazard_b     out  1  pending buffered write targets rf_raddr_b
  flag_z       out  1  zero flag
  flag_n       out  1  negative flag
  flag_c       out  1  carry flag
  wb_valid     out  1  one-cycle pulse: a register write committed on the previous edge
  wb_addr      out  3  register index of that commit
  busy         out  1  buffer non-empty

Function
REQ-003 A transfer SHALL occur on a rising edge where in_valid and in_ready are both high; {in_op, in_data, in_carry, in_dst} SHALL be pushed at the buffer tail.
REQ-004 in_ready SHALL be high exactly when buffer occupancy < DEPTH, derived from registered state only (no combinational path from in_valid).
REQ-005 The block SHALL commit the head entry on a rising edge where occupancy > 0 and wb_stall is low: rf[dst] <= data, entry popped.
REQ-006 An entry pushed at edge N SHALL NOT commit before edge N+1 (minimum latency one cycle, no bypass from input to register file).
REQ-007 Simultaneous push and pop SHALL leave occupancy unchanged and preserve FIFO order; a push while full SHALL be impossible because in_ready is low.
REQ-008 While wb_stall is high, no commit, no flag update and no wb_valid pulse SHALL occur; pushes SHALL continue until full.
REQ-009 On commit of an entry whose op is 8'h01, 8'h02, 8'h03 or 8'h04, flags SHALL update: flag_z = (data == 0), flag_n = data[7], flag_c = carry; for any other op, flags SHALL hold.
REQ-010 wb_valid SHALL be high for exactly the cycle following each commit, and wb_addr SHALL then hold that commit's dst; otherwise wb_valid SHALL be low and wb_addr SHALL hold its last value.
REQ-011 rf_rdata_a/b SHALL be combinational reads of the register file contents (committed values only); a read of an address being committed on the same edge SHALL return the old value before the edge.
REQ-012 hazard_a (hazard_b) SHALL be high when any valid buffer entry has dst equal to rf_raddr_a (rf_raddr_b).
REQ-013 busy SHALL equal (occupancy != 0).
REQ-014 Buffer pointers SHALL wrap modulo DEPTH; occupancy SHALL be tracked by a counter of width clog2(DEPTH+1).

Reset
REQ-015 When rst_n is low at a rising edge: occupancy = 0, pointers = 0, all eight registers = 8'h00, flag_z = flag_n = flag_c = 0, wb_valid = 0, wb_addr = 0.
REQ-016 Reset asserted mid-operation SHALL discard all pending entries without committing them; in_ready SHALL read high on the first cycle after reset release.
REQ-017 Reset SHALL take priority over push, commit and stall in the same cycle.

Structure
REQ-018 Opcode constants 8'h01..8'h04 (ALU-class ops), register-index width (3) and data width (8) SHALL reside in the shared package d8_pkg, used by both this block and the ALU output select stage.
REQ-019 The pending-result buffer SHALL be a separate sub-module d8_wb_fifo (push/pop, occupancy, head entry, per-entry valid and dst visibility for hazard compare).

Verification
REQ-020 Reset then push {op=01, data=8'h00, carry=1, dst=3}, wb_stall=0 -> edge+1: rf[3]=00, flag_z=1, flag_n=0, flag_c=1; next cycle wb_valid=1, wb_addr=3.
REQ-021 Push {op=05, data=8'h80, dst=2} after flags Z=1,C=1 -> rf[2]=80, flags unchanged.
REQ-022 Hold wb_stall=1, push three results -> in_ready low after two accepted (DEPTH=2), busy=1, hazard_a=1 for raddr_a=a pending dst; release stall -> commits in push order on consecutive edges, two wb_valid pulses.
REQ-023 Occupancy 1 with simultaneous push and commit over ten cycles -> occupancy stays 1, every datum committed in order, no loss.
REQ-024 Assert rst_n=0 with two pending entries -> no commit, all registers 00, flags 0, in_ready=1 after release.
